// File: rtl/elev_pkg.sv
// Shared types and helpers for the 4-floor elevator call scheduler.
package elev_pkg;

  localparam int unsigned NumFloors = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDn,
    StDoor
  } state_e;

  typedef enum logic {
    DirUp,
    DirDn
  } dir_e;

  function automatic logic [NumFloors-1:0] above_mask(floor_t f);
    logic [NumFloors-1:0] m;
    for (int i = 0; i < int'(NumFloors); i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NumFloors-1:0] below_mask(floor_t f);
    logic [NumFloors-1:0] m;
    for (int i = 0; i < int'(NumFloors); i++) m[i] = (i < int'(f));
    return m;
  endfunction

  // Index of the set bit; only meaningful when the input is one-hot.
  function automatic floor_t onehot_idx(logic [NumFloors-1:0] s);
    floor_t f;
    f = '0;
    for (int i = 0; i < int'(NumFloors); i++) begin
      if (s[i]) f = floor_t'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/elev_call_scheduler_if.sv
// Button/sensor inputs and motor/door/status outputs of the call scheduler.
interface elev_call_scheduler_if;
  logic [3:0] S;
  logic [2:0] U;
  logic [2:0] D;
  logic [3:0] F;
  logic       door_hold;
  logic       up;
  logic       down;
  logic       stop;
  logic       open_door;
  logic [1:0] cur_floor;
  logic [3:0] pend_up;
  logic [3:0] pend_dn;
  logic [3:0] pend_car;

  modport master (
    output S, U, D, F, door_hold,
    input  up, down, stop, open_door, cur_floor, pend_up, pend_dn, pend_car
  );

  modport slave (
    input  S, U, D, F, door_hold,
    output up, down, stop, open_door, cur_floor, pend_up, pend_dn, pend_car
  );
endinterface

// File: rtl/elev_door_timer.sv
// Door dwell counter: load/reload to DWELL_CYCLES-1, count down to 0, flag done.
module elev_door_timer #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elev_call_scheduler.sv
// SCAN call scheduler for a 4-floor car: latches calls, picks direction, times door dwell.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned CNT_W        = 4
) (
  input logic                  clk,
  input logic                  reset,
  elev_call_scheduler_if.slave bus
);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  floor_t     cur_floor_q, cur_floor_d;
  logic [3:0] pend_up_q, pend_up_d;
  logic [3:0] pend_dn_q, pend_dn_d;
  logic [3:0] pend_car_q, pend_car_d;

  logic       s_valid;
  floor_t     s_idx;
  floor_t     pos;
  logic [3:0] pend_all;
  logic       above_any;
  logic       below_any;
  logic       door_entry;
  logic       timer_done;

  assign s_valid   = $onehot(bus.S);
  assign s_idx     = onehot_idx(bus.S);
  assign pos       = s_valid ? s_idx : cur_floor_q;
  assign pend_all  = pend_up_q | pend_dn_q | pend_car_q;
  assign above_any = |(pend_all & above_mask(pos));
  assign below_any = |(pend_all & below_mask(pos));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_q       <= DirUp;
      cur_floor_q <= '0;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      pend_car_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_floor_q <= cur_floor_d;
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_car_q  <= pend_car_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid && pend_all[s_idx]) begin
          state_d = StDoor;
        end else if (above_any && below_any) begin
          state_d = (dir_q == DirUp) ? StMoveUp : StMoveDn;
        end else if (above_any) begin
          state_d = StMoveUp;
        end else if (below_any) begin
          state_d = StMoveDn;
        end
      end
      StMoveUp: begin
        if (s_valid && (pend_car_q[s_idx] || pend_up_q[s_idx] ||
                        (pend_dn_q[s_idx] && !above_any) || (s_idx == 2'd3))) begin
          state_d = StDoor;
        end
      end
      StMoveDn: begin
        if (s_valid && (pend_car_q[s_idx] || pend_dn_q[s_idx] ||
                        (pend_up_q[s_idx] && !below_any) || (s_idx == 2'd0))) begin
          state_d = StDoor;
        end
      end
      StDoor: begin
        if (timer_done && !bus.door_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q == StMoveUp && state_d != StMoveUp) dir_d = DirUp;
    if (state_q == StMoveDn && state_d != StMoveDn) dir_d = DirDn;
  end

  assign door_entry  = (state_d == StDoor) && (state_q != StDoor);
  assign cur_floor_d = s_valid ? s_idx : cur_floor_q;

  // Call latch: buttons set, DOOR entry clears; clear wins over a same-cycle set.
  always_comb begin
    logic [3:0] set_up, set_dn, set_car;
    logic [3:0] clr_up, clr_dn, clr_car;
    logic [3:0] f_bit;
    set_up  = {1'b0, bus.U};
    set_dn  = {bus.D, 1'b0};
    set_car = bus.F;
    clr_up  = '0;
    clr_dn  = '0;
    clr_car = '0;
    f_bit   = 4'b0001 << s_idx;
    if (state_q == StDoor) begin
      set_up  = set_up  & ~(4'b0001 << cur_floor_q);
      set_dn  = set_dn  & ~(4'b0001 << cur_floor_q);
      set_car = set_car & ~(4'b0001 << cur_floor_q);
    end
    if (door_entry) begin
      clr_car = f_bit;
      unique case (state_q)
        StMoveUp: begin
          clr_up = f_bit;
          if (!above_any) clr_dn = f_bit;
        end
        StMoveDn: begin
          clr_dn = f_bit;
          if (!below_any) clr_up = f_bit;
        end
        default: begin
          clr_up = f_bit;
          clr_dn = f_bit;
        end
      endcase
    end
    pend_up_d  = (pend_up_q  | set_up)  & ~clr_up;
    pend_dn_d  = (pend_dn_q  | set_dn)  & ~clr_dn;
    pend_car_d = (pend_car_q | set_car) & ~clr_car;
  end

  elev_door_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .CNT_W       (CNT_W)
  ) u_door_timer (
    .clk   (clk),
    .reset (reset),
    .load_i(door_entry || (state_q == StDoor && bus.door_hold)),
    .en_i  (state_q == StDoor),
    .done_o(timer_done)
  );

  // Moore output decode
  always_comb begin
    bus.up        = 1'b0;
    bus.down      = 1'b0;
    bus.stop      = 1'b1;
    bus.open_door = 1'b0;
    unique case (state_q)
      StMoveUp: begin
        bus.up   = 1'b1;
        bus.stop = 1'b0;
      end
      StMoveDn: begin
        bus.down = 1'b1;
        bus.stop = 1'b0;
      end
      StDoor:  bus.open_door = 1'b1;
      default: ;
    endcase
  end

  assign bus.cur_floor = cur_floor_q;
  assign bus.pend_up   = pend_up_q;
  assign bus.pend_dn   = pend_dn_q;
  assign bus.pend_car  = pend_car_q;

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Directed scenarios; expectations queued per cycle and checked by a negedge monitor.
module tb_elev_call_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elev_call_scheduler_if bus ();

  elev_call_scheduler #(
    .DWELL_CYCLES(8),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [17:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {up, down, stop, open_door, cur_floor, pend_up, pend_dn, pend_car}
  function automatic logic [17:0] pk(logic u, logic d, logic st, logic op, logic [1:0] cf,
                                     logic [3:0] pu, logic [3:0] pd, logic [3:0] pc);
    return {u, d, st, op, cf, pu, pd, pc};
  endfunction

  logic [17:0] act;
  assign act = {bus.up, bus.down, bus.stop, bus.open_door, bus.cur_floor,
                bus.pend_up, bus.pend_dn, bus.pend_car};

  always @(negedge clk) begin
    exp_t h;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      h = sb.pop_front();
      n_cmp++;
      if (h.cyc != cyc || act !== h.exp) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (cycle %0d, due %0d)", h.name, act, h.exp, cyc, h.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(string name, logic [17:0] e);
    sb.push_back('{cyc, name, e});
  endtask

  // n open cycles, then the closing edge back to IDLE
  task automatic dwell(string name, logic [17:0] e, int n);
    logic [17:0] c;
    for (int i = 0; i < n; i++) begin
      tick();
      ex({name, "_open"}, e);
    end
    c     = e;
    c[14] = 1'b0;
    tick();
    ex({name, "_close"}, c);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.S = 4'b0001;
    bus.U = '0;
    bus.D = '0;
    bus.F = '0;
    bus.door_hold = 1'b0;
    #1;
    n_cmp++;
    if (act !== pk(0, 0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h0)) begin
      n_bad++;
      $display("FAIL reset_immediate: got %b", act);
    end
    tick();
    ex("reset_state", pk(0, 0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    tick();
    reset = 1'b0;

    // Car call to floor3 from floor1
    bus.F = 4'b0100;
    tick(); bus.F = '0;
    ex("t1_latch", pk(0, 0, 1, 0, 2'd0, 4'h0, 4'h0, 4'b0100));
    tick(); ex("t1_up_2edges", pk(1, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'b0100));
    bus.S = 4'b0000;
    tick(); ex("t1_between", pk(1, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'b0100));
    bus.S = 4'b0010;
    tick(); ex("t1_pass_f2", pk(1, 0, 0, 0, 2'd1, 4'h0, 4'h0, 4'b0100));
    bus.S = 4'b0100;
    tick(); ex("t1_stop_f3", pk(0, 0, 1, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    n_cmp++;
    if (bus.open_door !== 1'b1 || bus.stop !== 1'b1) begin
      n_bad++;
      $display("FAIL t1_door_direct: open_door %b stop %b", bus.open_door, bus.stop);
    end
    dwell("t1", pk(0, 0, 1, 1, 2'd2, 4'h0, 4'h0, 4'h0), 7);

    // Idle at floor3, calls both ways, last_dir up
    bus.U = 3'b001;
    bus.F = 4'b1000;
    tick(); bus.U = '0; bus.F = '0;
    ex("t3_latch", pk(0, 0, 1, 0, 2'd2, 4'b0001, 4'h0, 4'b1000));
    tick(); ex("t3_up_first", pk(1, 0, 0, 0, 2'd2, 4'b0001, 4'h0, 4'b1000));
    bus.S = 4'b1000;
    tick(); ex("t3_stop_f4", pk(0, 0, 1, 1, 2'd3, 4'b0001, 4'h0, 4'h0));
    dwell("t3a", pk(0, 0, 1, 1, 2'd3, 4'b0001, 4'h0, 4'h0), 7);
    tick(); ex("t3_down", pk(0, 1, 0, 0, 2'd3, 4'b0001, 4'h0, 4'h0));
    bus.S = 4'b0100;
    tick(); ex("t3_pass_f3", pk(0, 1, 0, 0, 2'd2, 4'b0001, 4'h0, 4'h0));
    bus.S = 4'b0010;
    tick(); ex("t3_pass_f2", pk(0, 1, 0, 0, 2'd1, 4'b0001, 4'h0, 4'h0));
    bus.S = 4'b0001;
    tick(); ex("t3_stop_f1", pk(0, 0, 1, 1, 2'd0, 4'h0, 4'h0, 4'h0));
    dwell("t3b", pk(0, 0, 1, 1, 2'd0, 4'h0, 4'h0, 4'h0), 7);

    // Up with down call at floor2 and car call at floor4; sensor glitches en route
    bus.D = 3'b001;
    bus.F = 4'b1000;
    tick(); bus.D = '0; bus.F = '0;
    ex("t2_latch", pk(0, 0, 1, 0, 2'd0, 4'h0, 4'b0010, 4'b1000));
    tick(); ex("t2_up", pk(1, 0, 0, 0, 2'd0, 4'h0, 4'b0010, 4'b1000));
    bus.S = 4'b0010;
    tick(); ex("t2_pass_f2", pk(1, 0, 0, 0, 2'd1, 4'h0, 4'b0010, 4'b1000));
    bus.S = 4'b0000;
    tick(); ex("t5_sensor_zero", pk(1, 0, 0, 0, 2'd1, 4'h0, 4'b0010, 4'b1000));
    bus.S = 4'b0110;
    tick(); ex("t5_sensor_multi", pk(1, 0, 0, 0, 2'd1, 4'h0, 4'b0010, 4'b1000));
    bus.S = 4'b1000;
    tick(); ex("t2_stop_f4", pk(0, 0, 1, 1, 2'd3, 4'h0, 4'b0010, 4'h0));
    dwell("t2a", pk(0, 0, 1, 1, 2'd3, 4'h0, 4'b0010, 4'h0), 7);
    tick(); ex("t2_down", pk(0, 1, 0, 0, 2'd3, 4'h0, 4'b0010, 4'h0));
    bus.S = 4'b0100;
    tick(); ex("t2_pass_f3", pk(0, 1, 0, 0, 2'd2, 4'h0, 4'b0010, 4'h0));
    bus.S = 4'b0010;
    tick(); ex("t2_stop_f2", pk(0, 0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0));
    dwell("t2b", pk(0, 0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0), 7);

    // Door hold for 20 cycles
    bus.F = 4'b0010;
    tick(); bus.F = '0;
    ex("t4_latch", pk(0, 0, 1, 0, 2'd1, 4'h0, 4'h0, 4'b0010));
    tick(); ex("t4_open", pk(0, 0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0));
    bus.door_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      ex("t4_hold", pk(0, 0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0));
    end
    bus.door_hold = 1'b0;
    dwell("t4", pk(0, 0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0), 7);

    // Forced top stop, masked hall call at door floor, then async reset mid-move
    bus.F = 4'b0100;
    tick(); bus.F = '0;
    ex("t6_latch", pk(0, 0, 1, 0, 2'd1, 4'h0, 4'h0, 4'b0100));
    tick(); ex("t6_up", pk(1, 0, 0, 0, 2'd1, 4'h0, 4'h0, 4'b0100));
    bus.S = 4'b1000;
    tick(); ex("t6_top_stop", pk(0, 0, 1, 1, 2'd3, 4'h0, 4'h0, 4'b0100));
    bus.D = 3'b100;
    bus.F = 4'b0001;
    tick(); bus.D = '0; bus.F = '0;
    ex("t6_dn_masked", pk(0, 0, 1, 1, 2'd3, 4'h0, 4'h0, 4'b0101));
    dwell("t6", pk(0, 0, 1, 1, 2'd3, 4'h0, 4'h0, 4'b0101), 6);
    tick(); ex("t6_down", pk(0, 1, 0, 0, 2'd3, 4'h0, 4'h0, 4'b0101));
    bus.S = 4'b0000;
    tick();
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (act !== pk(0, 0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h0)) begin
      n_bad++;
      $display("FAIL t5_async_direct: got %b", act);
    end
    ex("t5_async_reset", pk(0, 0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    tick();
    reset = 1'b0;
    tick();
    tick();

    if (n_cmp < 12 || n_bad != 0) begin
      $display("FAIL overall: %0d compared / %0d mismatched", n_cmp, n_bad);
    end else begin
      $display("PASS");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
